// File: rtl/gray_conv_pkg.sv
// Shared encodings for the Gray-code converter scheduler: FSM states and conversion modes.
package gray_conv_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StConv = ST_CONV,
      StResp = ST_RESP
   } state_e;

endpackage

// File: rtl/gray_conv_scheduler_if.sv
// Request/response bundle between NREQ clients and the shared converter scheduler.
interface gray_conv_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int IDW   = 2
);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       req_mode;
   logic [NREQ*WIDTH-1:0] req_data;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WIDTH-1:0]      rsp_data;
   logic [IDW-1:0]        rsp_id;
   logic                  rsp_mode;

   // Client side: issues requests, consumes responses.
   modport master (
      output req_valid, req_mode, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_mode
   );

   // Scheduler side.
   modport slave (
      input  req_valid, req_mode, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_mode
   );

endinterface

// File: rtl/gray_codec.sv
// Purely combinational binary<->Gray converter, shared by all requesters.
module gray_codec
   import gray_conv_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] data,
   input  logic             mode,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] b2g;
   logic [WIDTH-1:0] g2b;

   assign b2g = data ^ (data >> 1);

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      g2b = '0;
      for (int i = 0; i < WIDTH; i++) begin
         g2b[i] = ^(data >> i);
      end
   end

   always_comb begin
      result = b2g;
      unique case (mode)
         MODE_B2G: result = b2g;
         MODE_G2B: result = g2b;
         default:  result = b2g;
      endcase
   end

endmodule

// File: rtl/gray_conv_scheduler.sv
// Round-robin scheduler sharing one gray_codec among NREQ requesters; one result per
// accepted request, returned with the requester ID over a valid/ready channel.
module gray_conv_scheduler
   import gray_conv_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int IDW   = 2
) (
   input logic                clk,
   input logic                rst,
   gray_conv_scheduler_if.slave bus
);

   state_e           state_q, state_d;
   logic [IDW-1:0]   last_grant_q;

   logic [WIDTH-1:0] op_data_q;
   logic             op_mode_q;
   logic [IDW-1:0]   op_id_q;

   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic [IDW-1:0]   rsp_id_q;
   logic             rsp_mode_q;

   logic             grant_vld;
   logic [IDW-1:0]   grant_idx;
   logic             hi_found;
   logic [IDW-1:0]   hi_idx;
   logic [IDW-1:0]   lo_idx;

   logic [WIDTH-1:0] sel_data;
   logic             sel_mode;
   logic [NREQ-1:0]  req_ready_d;
   logic [WIDTH-1:0] conv_result;

   logic             accept;
   logic             load_rsp;
   logic             rsp_done;

   // Round-robin search: lowest valid lane above last_grant wins, else lowest valid lane
   // overall (the wrap). Descending loops leave the lowest match in the *_idx variables.
   always_comb begin
      grant_vld = 1'b0;
      hi_found  = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            grant_vld = 1'b1;
            lo_idx    = IDW'(i);
            if (i > int'(last_grant_q)) begin
               hi_found = 1'b1;
               hi_idx   = IDW'(i);
            end
         end
      end
      grant_idx = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      sel_data = '0;
      sel_mode = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            sel_data = bus.req_data[i*WIDTH +: WIDTH];
            sel_mode = bus.req_mode[i];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      load_rsp = 1'b0;
      rsp_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_vld) begin
               accept  = 1'b1;
               state_d = StConv;
            end
         end
         StConv: begin
            load_rsp = 1'b1;
            state_d  = StResp;
         end
         StResp: begin
            if (bus.rsp_ready) begin
               rsp_done = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready_d[i] = accept && (grant_idx == IDW'(i));
      end
   end

   gray_codec #(
      .WIDTH (WIDTH)
   ) u_codec (
      .data   (op_data_q),
      .mode   (op_mode_q),
      .result (conv_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= IDW'(NREQ - 1);
         op_data_q    <= '0;
         op_mode_q    <= 1'b0;
         op_id_q      <= '0;
      end else if (accept) begin
         last_grant_q <= grant_idx;
         op_data_q    <= sel_data;
         op_mode_q    <= sel_mode;
         op_id_q      <= grant_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         rsp_mode_q  <= 1'b0;
      end else if (load_rsp) begin
         rsp_valid_q <= 1'b1;
         rsp_data_q  <= conv_result;
         rsp_id_q    <= op_id_q;
         rsp_mode_q  <= op_mode_q;
      end else if (rsp_done) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.req_ready = req_ready_d;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_mode  = rsp_mode_q;

   a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
   a_id_range: assert property (@(posedge clk) disable iff (rst) int'(bus.rsp_id) < NREQ);

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Scoreboard bench for gray_conv_scheduler: expected results queued at request time,
// popped and compared on each response handshake.
module tb_gray_conv_scheduler;
   import gray_conv_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int IDW   = 2;

   typedef struct packed {
      logic [IDW-1:0]   id;
      logic             mode;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   exp_t sb[$];
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   cyc      = 0;
   int   last_pop = 0;
   bit   gap_en   = 1'b0;
   bit   gap_have = 1'b0;

   always #5 clk = ~clk;

   gray_conv_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   gray_conv_scheduler #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .IDW   (IDW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [WIDTH-1:0] m_b2g(input logic [WIDTH-1:0] b);
      return b ^ {1'b0, b[WIDTH-1:1]};
   endfunction

   function automatic logic [WIDTH-1:0] m_g2b(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int lane, input logic mode, input logic [WIDTH-1:0] d);
      exp_t e;
      e.id   = IDW'(lane);
      e.mode = mode;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic req(input int lane, input logic mode, input logic [WIDTH-1:0] d);
      bus.req_mode[lane]                = mode;
      bus.req_data[lane*WIDTH +: WIDTH] = d;
      bus.req_valid[lane]               = 1'b1;
   endtask

   task automatic req_conv(input int lane, input logic mode, input logic [WIDTH-1:0] d);
      req(lane, mode, d);
      push_exp(lane, mode, (mode == MODE_G2B) ? m_g2b(d) : m_b2g(d));
   endtask

   // Called at a falling edge; returns at the next falling edge. Handles both handshakes.
   task automatic step();
      logic [NREQ-1:0] hs;
      exp_t            e;
      #1;
      hs = bus.req_valid & bus.req_ready;
      check_eq("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
      if (bus.rsp_valid && bus.rsp_ready) begin
         check_eq("rsp_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check_eq("rsp_mode", 32'(bus.rsp_mode), 32'(e.mode));
            check_eq("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            if (gap_en && gap_have) check_eq("rr_gap", 32'(cyc - last_pop), 32'd3);
            gap_have = 1'b1;
            last_pop = cyc;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NREQ; i++) if (hs[i]) bus.req_valid[i] = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || bus.req_valid != '0 || bus.rsp_valid) && n < budget) begin
         step();
         n++;
      end
      check_eq("drain_done", 32'(sb.size() != 0 || bus.req_valid != '0), 32'd0);
   endtask

   task automatic wait_rsp(input int budget);
      int n = 0;
      while (!bus.rsp_valid && n < budget) begin
         step();
         n++;
      end
      check_eq("rsp_seen", 32'(bus.rsp_valid), 32'd1);
   endtask

   // Called at a falling edge; asserts reset mid-cycle and checks outputs clear at once.
   task automatic do_reset();
      #2;
      rst           = 1'b1;
      bus.req_valid = '0;
      sb.delete();
      gap_en   = 1'b0;
      gap_have = 1'b0;
      #1;
      check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      check_eq("rst_rsp_mode", 32'(bus.rsp_mode), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_mode  = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Idle after reset
      repeat (3) begin
         step();
         check_eq("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         check_eq("idle_req_ready", 32'(bus.req_ready), 32'd0);
      end

      // Async reset while holding a response
      req(2, MODE_G2B, 4'b0110);
      wait_rsp(8);
      check_eq("pre_rst_data", 32'(bus.rsp_data), 32'(4'b0100));
      check_eq("pre_rst_id", 32'(bus.rsp_id), 32'd2);
      do_reset();

      // Single bin->gray with exact latency
      bus.rsp_ready = 1'b1;
      req_conv(0, MODE_B2G, 4'b1011);
      #1;
      check_eq("t0_req_ready", 32'(bus.req_ready), 32'(4'b0001));
      step();
      check_eq("t1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      step();
      check_eq("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("t2_rsp_data", 32'(bus.rsp_data), 32'(4'b1110));
      drain(10);

      // Single gray->bin on requester 2
      req_conv(2, MODE_G2B, 4'b1110);
      drain(10);

      // Sweep both directions on requester 1; round trip must return x
      for (int x = 0; x < 16; x++) begin
         req_conv(1, MODE_B2G, WIDTH'(x));
         drain(10);
         req(1, MODE_G2B, m_b2g(WIDTH'(x)));
         push_exp(1, MODE_G2B, WIDTH'(x));
         drain(10);
      end

      // All requesters from reset: order 0,1,2,3, one every 3 cycles
      do_reset();
      bus.rsp_ready = 1'b1;
      gap_en        = 1'b1;
      for (int i = 0; i < NREQ; i++) req_conv(i, logic'(i % 2), WIDTH'(3 * i + 1));
      drain(30);
      gap_en = 1'b0;

      // After grant to 2, requester 3 beats requester 1
      req_conv(2, MODE_B2G, 4'b1000);
      drain(10);
      req(1, MODE_B2G, 4'b0011);
      req(3, MODE_G2B, 4'b0111);
      push_exp(3, MODE_G2B, m_g2b(4'b0111));
      push_exp(1, MODE_B2G, m_b2g(4'b0011));
      drain(20);

      // Backpressure
      do_reset();
      bus.rsp_ready = 1'b0;
      req_conv(0, MODE_B2G, 4'b0101);
      req_conv(3, MODE_G2B, 4'b1001);
      wait_rsp(6);
      repeat (5) begin
         check_eq("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check_eq("bp_rsp_data", 32'(bus.rsp_data), 32'(4'b0111));
         check_eq("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
         check_eq("bp_rsp_mode", 32'(bus.rsp_mode), 32'd0);
         check_eq("bp_req_ready", 32'(bus.req_ready), 32'd0);
         step();
      end
      bus.rsp_ready = 1'b1;
      step();
      #1;
      check_eq("bp_next_grant", 32'(bus.req_ready), 32'(4'b1000));
      drain(10);

      // Reset while in CONV discards the operand
      req(3, MODE_B2G, 4'b0110);
      step();
      check_eq("conv_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      do_reset();
      repeat (4) begin
         step();
         check_eq("discard_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end
      req_conv(0, MODE_B2G, 4'b1100);
      req_conv(2, MODE_G2B, 4'b1010);
      drain(20);

      // Reset restores requester 0 priority after a grant to 1
      req_conv(1, MODE_B2G, 4'b0001);
      drain(10);
      do_reset();
      req_conv(0, MODE_G2B, 4'b1111);
      req_conv(2, MODE_B2G, 4'b1111);
      drain(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gray_conv_scheduler.md
Name: gray_conv_scheduler

Overview:
Round-robin scheduler that shares one binary/Gray code converter among NREQ requesters. Each request selects a direction: binary->Gray or Gray->binary. The block arbitrates between requests, latches the winner's operand, computes the result in the shared converter, and returns it with the requester ID over a valid/ready response channel. It sits between multiple client blocks and the single converter datapath, so the converter logic is not replicated per client.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, operand/result width in bits
IDW, 2, requester-ID width; must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
req_mode  in  NREQ  per-requester direction: 0 = bin->gray, 1 = gray->bin
req_data  in  NREQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH]
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accepts result
rsp_data  out  WIDTH  converted value
rsp_id  out  IDW  index of the requester that owns rsp_data
rsp_mode  out  1  direction used for this result

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state=IDLE; req_ready=0; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_mode=0; rr pointer last_grant=NREQ-1, so requester 0 has highest priority first.
- States: IDLE, CONV, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[grant] is asserted combinationally in the same cycle; the handshake completes that cycle.
  - On the edge: latch op_data, op_mode and op_id; last_grant <= grant; go to CONV.
  - No req_valid: stay in IDLE with req_ready=0.
- CONV (1 cycle):
  - rsp_data <= converter(op_data, op_mode); rsp_id <= op_id; rsp_mode <= op_mode; rsp_valid <= 1; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_mode are held stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid <= 0; go to IDLE.
  - req_ready=0 throughout CONV and RESP; no new request is accepted.
- Latency: accept at cycle T -> rsp_valid high at T+2. Best-case throughput is one result per 3 cycles (rsp_ready tied high).
- Converter arithmetic:
  - bin->gray: g = b ^ (b >> 1).
  - gray->bin: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
  - Pure WIDTH-bit logic, no carries.
- Requester protocol: req_valid, req_mode and req_data must stay stable until req_ready. The scheduler samples only the granted lane, only in the handshake cycle. Changes on non-granted lanes are ignored.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep waiting. Round-robin guarantees each requester is served within NREQ grants.
- Single requester: the same requester may win repeatedly, one grant per 3 cycles.
- Reset mid-operation: any state returns to IDLE, all outputs go to reset values, and the in-flight operand is discarded with no response. Requesters must re-present.
- Out-of-range lanes: requesters >= NREQ do not exist; rsp_id never exceeds NREQ-1.

Decomposition:
- Package gray_conv_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_CONV=2'd1, ST_RESP=2'd2.
  - mode constants MODE_B2G=1'b0, MODE_G2B=1'b1.
- Sub-module gray_codec (parameter WIDTH; inputs data, mode; output result; purely combinational). Instantiated once as the shared converter. The scheduler holds the FSM, arbiter and registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> req_ready=0, rsp_valid=0, rsp_data=0 immediately. After release with no requests, all outputs remain idle.
- Single b2g: req_valid[0]=1, mode=0, data=4'b1011 at cycle T -> req_ready[0]=1 at T; rsp_valid=1, rsp_data=4'b1110, rsp_id=0, rsp_mode=0 at T+2.
- Single g2b: requester 2, mode=1, data=4'b1110 -> rsp_data=4'b1011, rsp_id=2. Also sweep all 16 values both directions on requester 1 -> g2b(b2g(x))==x for every x.
- Arbitration: all four requesters valid from reset, rsp_ready=1 -> grants/rsp_id in order 0,1,2,3, one every 3 cycles. Then after a grant to 2 with only requesters 1 and 3 valid -> 3 is served before 1.
- Backpressure: rsp_ready=0 for 5 cycles while rsp_valid=1 -> rsp_data, rsp_id and rsp_mode stay constant; req_ready stays 0 for all lanes despite pending req_valid. The result is consumed on the first cycle rsp_ready=1 and the next grant follows in the next IDLE cycle.
- Reset mid-operation: pulse rst while in CONV (request 4'b0110 from requester 3 accepted) -> no rsp_valid is produced. After release, requester 0 has highest priority again.
